// File: rtl/mmio_pkg.sv
// Address map and read-word layout shared by the MMIO hub and its bench.
// Optional glitch filter in the channels is enabled by MMIO_HUB_DEBOUNCE_EN.
package mmio_pkg;

  localparam int unsigned READ_STATUS_ADDR = 15;
  localparam int unsigned WRITE_BASE       = 16;
  localparam int unsigned MMIO_LIMIT       = 32;

  localparam int unsigned LEVEL_BIT = 0;
  localparam int unsigned COUNT_LSB = 1;

  typedef enum logic [1:0] {
    REGION_READ,
    REGION_WRITE,
    REGION_NONE
  } region_e;

  function automatic region_e decode_region(input logic [31:0] addr);
    region_e region;
    if (addr < 32'(WRITE_BASE)) begin
      region = REGION_READ;
    end else if (addr < 32'(MMIO_LIMIT)) begin
      region = REGION_WRITE;
    end else begin
      region = REGION_NONE;
    end
    return region;
  endfunction

  // Channel read word: level in bit 0, count above it, zeros elsewhere.
  function automatic logic [31:0] pack_chan_word(input logic [30:0] count,
                                                 input logic        level);
    logic [31:0] word;
    word                 = '0;
    word[LEVEL_BIT]      = level;
    word[COUNT_LSB +: 31] = count;
    return word;
  endfunction

endpackage

// File: rtl/mmio_in_chan.sv
// One sensed input: 2-flop synchronizer, optional glitch filter (MMIO_HUB_DEBOUNCE_EN),
// rising-edge detector and saturating event counter with a clear strobe.
module mmio_in_chan #(
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw,
  input  logic             clear,
  output logic             level,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [1:0]       fill_reg;
  logic             filt_level;
  logic             prev_reg;
  logic             armed_reg;
  logic             edge_pulse;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // fill_reg marks when sync2_reg holds a sample taken after reset release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      fill_reg  <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
    end
  end

`ifdef MMIO_HUB_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             filt_reg;
  logic [DEB_W-1:0] deb_cnt_reg;

  // deb_cnt_reg counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      filt_reg    <= 1'b0;
      deb_cnt_reg <= '0;
    end else if (sync2_reg == filt_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
      filt_reg    <= sync2_reg;
      deb_cnt_reg <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  assign filt_level = filt_reg;
`else
  assign filt_level = sync2_reg;
`endif

  // Edges are only counted once a genuine low has been seen after reset,
  // so a level already high at release does not count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      prev_reg  <= filt_level;
      if (fill_reg[1] && !sync2_reg && !filt_level) begin
        armed_reg <= 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign edge_pulse = armed_reg & filt_level & ~prev_reg;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = edge_pulse ? CNT_W'(1) : '0;
    end else if (edge_pulse && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  assign level   = filt_level;
  assign count   = count_reg;
  assign nonzero = (count_reg != '0);

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped hub: per-input event counters readable at 0..NUM_IN-1, status at 15,
// CPU output registers at 16+j. Build with MMIO_HUB_DEBOUNCE_EN to enable input filtering.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 9,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_dmem,
  input  logic                  wren,
  input  logic [31:0]           data,
  output logic [31:0]           q_mmio,
  output logic                  is_mmio_rd,
  input  logic [NUM_IN-1:0]     in_raw,
  output logic [NUM_OUT*32-1:0] out_regs,
  output logic                  event_pending
);

  region_e           region;
  logic [NUM_IN-1:0] chan_level;
  logic [NUM_IN-1:0] chan_clear;
  logic [NUM_IN-1:0] chan_nonzero;
  logic [31:0]       chan_word [NUM_IN];
  logic [31:0]       status_word;
  logic [31:0]       q_word;
  logic              event_pending_reg;

  assign region     = decode_region(address_dmem);
  assign is_mmio_rd = (region == REGION_READ);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt;

      assign chan_clear[gi] = wren && (region == REGION_READ) &&
                              (address_dmem == 32'(gi));

      mmio_in_chan #(
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_chan (
        .clock   (clock),
        .reset   (reset),
        .raw     (in_raw[gi]),
        .clear   (chan_clear[gi]),
        .level   (chan_level[gi]),
        .count   (cnt),
        .nonzero (chan_nonzero[gi])
      );

      assign chan_word[gi] = pack_chan_word(31'(cnt), chan_level[gi]);
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [31:0] val_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          val_reg <= '0;
        end else if (wren && (region == REGION_WRITE) &&
                     (address_dmem == 32'(WRITE_BASE + gi))) begin
          val_reg <= data;
        end
      end

      assign out_regs[32*gi +: 32] = val_reg;
    end
  endgenerate

  assign status_word = 32'(chan_nonzero);

  // Unmapped read addresses below 16 fall through to zero.
  always_comb begin
    q_word = '0;
    if (address_dmem == 32'(READ_STATUS_ADDR)) begin
      q_word = status_word;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (address_dmem == 32'(i)) begin
          q_word = chan_word[i];
        end
      end
    end
  end

  assign q_mmio = q_word;

  always_ff @(posedge clock) begin
    if (!reset) begin
      event_pending_reg <= 1'b0;
    end else begin
      event_pending_reg <= |chan_nonzero;
    end
  end

  assign event_pending = event_pending_reg;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: directed scenarios plus randomized traffic
// checked against an event-level model of counts and output registers.
`timescale 1ns/1ps
module tb_mmio_hub;

  localparam int NUM_IN     = 4;
  localparam int NUM_OUT    = 9;
  localparam int CNT_W      = 8;
  localparam int DEB_CYCLES = 1000;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [31:0]           address_dmem = '0;
  logic                  wren = 1'b0;
  logic [31:0]           data = '0;
  logic [NUM_IN-1:0]     in_raw = '0;
  logic [31:0]           q_mmio;
  logic                  is_mmio_rd;
  logic [NUM_OUT*32-1:0] out_regs;
  logic                  event_pending;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          exp_cnt [NUM_IN];
  logic [31:0] exp_out [NUM_OUT];

  mmio_hub #(
    .NUM_IN     (NUM_IN),
    .NUM_OUT    (NUM_OUT),
    .CNT_W      (CNT_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address_dmem  (address_dmem),
    .wren          (wren),
    .data          (data),
    .q_mmio        (q_mmio),
    .is_mmio_rd    (is_mmio_rd),
    .in_raw        (in_raw),
    .out_regs      (out_regs),
    .event_pending (event_pending)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic bit pulse_counts(int hi);
`ifdef MMIO_HUB_DEBOUNCE_EN
    return hi >= DEB_CYCLES;
`else
    return hi >= 1;
`endif
  endfunction

  function automatic logic [31:0] exp_word(int ch, bit lvl);
    return (32'(exp_cnt[ch]) << 1) | 32'(lvl);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NUM_IN; i++) if (exp_cnt[i] != 0) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [NUM_OUT*32-1:0] exp_out_vec();
    logic [NUM_OUT*32-1:0] v;
    for (int j = 0; j < NUM_OUT; j++) v[j*32 +: 32] = exp_out[j];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_IN; i++) exp_cnt[i] = 0;
    for (int j = 0; j < NUM_OUT; j++) exp_out[j] = '0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    tick(1);
    wren = 1'b0;
    if (a < 32'(NUM_IN)) exp_cnt[a] = 0;
    else if (a >= 32'd16 && a < 32'(16 + NUM_OUT)) exp_out[a - 32'd16] = d;
  endtask

  task automatic pulse(int ch, int hi, int lo);
    in_raw[ch] = 1'b1;
    tick(hi);
    in_raw[ch] = 1'b0;
    tick(lo);
    if (pulse_counts(hi) && exp_cnt[ch] < CNT_MAX) exp_cnt[ch]++;
  endtask

  task automatic read(logic [31:0] a, output logic [31:0] w);
    address_dmem = a;
    #1;
    w = q_mmio;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] w;
    reset = 1'b0;
    in_raw = '0;
    model_reset();
    tick(3);
    for (int a = 0; a < NUM_IN; a++) begin
      read(32'(a), w);
      total_cnt++;
      if (w !== 32'h0) $display("FAIL reset_chan addr=%0d got=%h want=%h", a, w, 32'h0);
      else pass_cnt++;
    end
    read(32'd15, w);
    total_cnt++;
    if (w !== 32'h0) $display("FAIL reset_status got=%h want=%h", w, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (out_regs !== '0) $display("FAIL reset_out_regs got=%h want=0", out_regs);
    else pass_cnt++;
    total_cnt++;
    if (event_pending !== 1'b0) $display("FAIL reset_event_pending got=%b want=0", event_pending);
    else pass_cnt++;
    reset = 1'b1;
    tick(3);
  endtask

  task automatic test_writes();
    logic [31:0] w;
    store(32'd23, 32'h5A);
    total_cnt++;
    if (out_regs[7*32 +: 32] !== 32'h5A)
      $display("FAIL write_addr23 got=%h want=%h", out_regs[7*32 +: 32], 32'h5A);
    else pass_cnt++;
    total_cnt++;
    if (out_regs !== exp_out_vec()) $display("FAIL write_others got=%h want=%h", out_regs, exp_out_vec());
    else pass_cnt++;
    store(32'd30, 32'hCAFE_0001);
    store(32'd40, 32'hCAFE_0002);
    store(32'hFFFF_0011, 32'hCAFE_0003);
    total_cnt++;
    if (out_regs !== exp_out_vec()) $display("FAIL write_ignored got=%h want=%h", out_regs, exp_out_vec());
    else pass_cnt++;
    store(32'd5, 32'h1234);
    store(32'd15, 32'h5678);
    read(32'd15, w);
    total_cnt++;
    if (w !== exp_status()) $display("FAIL write_status_untouched got=%h want=%h", w, exp_status());
    else pass_cnt++;
    read(32'd5, w);
    total_cnt++;
    if (w !== 32'h0) $display("FAIL read_unused got=%h want=%h", w, 32'h0);
    else pass_cnt++;
    read(32'd15, w);
    total_cnt++;
    if (is_mmio_rd !== 1'b1) $display("FAIL is_mmio_rd_15 got=%b want=1", is_mmio_rd);
    else pass_cnt++;
    read(32'd16, w);
    total_cnt++;
    if (is_mmio_rd !== 1'b0) $display("FAIL is_mmio_rd_16 got=%b want=0", is_mmio_rd);
    else pass_cnt++;
  endtask

`ifndef MMIO_HUB_DEBOUNCE_EN
  task automatic test_three_pulses();
    logic [31:0] w;
    store(32'd1, 32'h0);
    for (int k = 0; k < 3; k++) pulse(1, 10, 10);
    read(32'd1, w);
    total_cnt++;
    if (w !== 32'h6) $display("FAIL three_pulses got=%h want=%h", w, 32'h6);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [31:0] w;
    for (int k = 0; k < 300; k++) pulse(0, 2, 2);
    tick(4);
    read(32'd0, w);
    total_cnt++;
    if (w !== 32'h1FE) $display("FAIL saturate_count got=%h want=%h", w, 32'h1FE);
    else pass_cnt++;
    read(32'd15, w);
    total_cnt++;
    if (w !== exp_status() || w[0] !== 1'b1)
      $display("FAIL saturate_status got=%h want=%h", w, exp_status());
    else pass_cnt++;
    total_cnt++;
    if (event_pending !== 1'b1) $display("FAIL saturate_event_pending got=%b want=1", event_pending);
    else pass_cnt++;
  endtask

  task automatic test_clear_edge();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) pulse(2, 3, 4);
    read(32'd2, w);
    total_cnt++;
    if (w !== 32'h6) $display("FAIL clear_edge_pre got=%h want=%h", w, 32'h6);
    else pass_cnt++;
    // Rise lands in the counter two edges later; the clear is timed onto that edge.
    in_raw[2] = 1'b1;
    tick(2);
    address_dmem = 32'd2;
    wren = 1'b1;
    tick(1);
    wren = 1'b0;
    read(32'd2, w);
    total_cnt++;
    if (w !== 32'h3) $display("FAIL clear_edge_same_cycle got=%h want=%h", w, 32'h3);
    else pass_cnt++;
    in_raw[2] = 1'b0;
    exp_cnt[2] = 1;
    tick(4);
    read(32'd2, w);
    total_cnt++;
    if (w !== exp_word(2, 1'b0)) $display("FAIL clear_edge_post got=%h want=%h", w, exp_word(2, 1'b0));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] w;
    store(32'd3, 32'h0);
    for (int k = 0; k < 4; k++) pulse(3, 3, 3);
    read(32'd3, w);
    total_cnt++;
    if (w !== 32'h8) $display("FAIL midreset_pre got=%h want=%h", w, 32'h8);
    else pass_cnt++;
    store(32'd16, 32'hDEAD_BEEF);
    in_raw[3] = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    model_reset();
    for (int a = 0; a < NUM_IN; a++) begin
      read(32'(a), w);
      total_cnt++;
      if (w !== 32'h0) $display("FAIL midreset_chan addr=%0d got=%h want=0", a, w);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_regs !== '0 || event_pending !== 1'b0)
      $display("FAIL midreset_outputs got=%h/%b want=0/0", out_regs, event_pending);
    else pass_cnt++;
    reset = 1'b1;
    tick(20);
    read(32'd3, w);
    total_cnt++;
    if (w !== 32'h1) $display("FAIL midreset_held_high got=%h want=%h", w, 32'h1);
    else pass_cnt++;
    total_cnt++;
    if (event_pending !== 1'b0) $display("FAIL midreset_event_pending got=%b want=0", event_pending);
    else pass_cnt++;
    in_raw[3] = 1'b0;
    tick(4);
    pulse(3, 4, 4);
    read(32'd3, w);
    total_cnt++;
    if (w !== 32'h2) $display("FAIL midreset_recount got=%h want=%h", w, 32'h2);
    else pass_cnt++;
  endtask
`endif

`ifdef MMIO_HUB_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] w;
    store(32'd0, 32'h0);
    tick(4);
    pulse(0, 500, 1500);
    read(32'd0, w);
    total_cnt++;
    if (w !== 32'h0) $display("FAIL debounce_short got=%h want=%h", w, 32'h0);
    else pass_cnt++;
    pulse(0, 1500, 1500);
    read(32'd0, w);
    total_cnt++;
    if (w !== 32'h2) $display("FAIL debounce_long got=%h want=%h", w, 32'h2);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    int          op;
    for (int it = 0; it < 50; it++) begin
      op = int'($urandom_range(0, 3));
      if (op <= 1) pulse(int'($urandom_range(0, NUM_IN - 1)), int'($urandom_range(2, 6)),
                         int'($urandom_range(3, 6)));
      else if (op == 2) store(32'($urandom_range(0, NUM_IN - 1)), $urandom);
      else store(32'($urandom_range(0, 40)), $urandom);
      tick(3);
      for (int a = 0; a < NUM_IN; a++) begin
        read(32'(a), w);
        total_cnt++;
        if (w !== exp_word(a, 1'b0))
          $display("FAIL rand_chan it=%0d addr=%0d got=%h want=%h", it, a, w, exp_word(a, 1'b0));
        else pass_cnt++;
      end
      read(32'd15, w);
      total_cnt++;
      if (w !== exp_status()) $display("FAIL rand_status it=%0d got=%h want=%h", it, w, exp_status());
      else pass_cnt++;
      total_cnt++;
      if (event_pending !== (exp_status() != 0))
        $display("FAIL rand_event_pending it=%0d got=%b want=%b", it, event_pending, exp_status() != 0);
      else pass_cnt++;
      total_cnt++;
      if (out_regs !== exp_out_vec())
        $display("FAIL rand_out_regs it=%0d got=%h want=%h", it, out_regs, exp_out_vec());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_writes();
`ifndef MMIO_HUB_DEBOUNCE_EN
    test_three_pulses();
    test_saturation();
    test_clear_edge();
`endif
    test_random();
`ifndef MMIO_HUB_DEBOUNCE_EN
    test_reset_mid_pulse();
`else
    test_debounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning number of sensed input channels (1..15).
REQ-002 SHALL have parameter NUM_OUT, default 9, meaning number of CPU-writable output registers (1..16).
REQ-003 SHALL have parameter CNT_W, default 8, meaning event-counter width per input channel (1..30).
REQ-004 SHALL have parameter DEB_CYCLES, default 1000, meaning the stable-sample count used by the glitch filter.
REQ-005 SHALL have port clock, input, 1, the single system clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port address_dmem, input, 32, CPU data address.
REQ-008 SHALL have port wren, input, 1, CPU store strobe.
REQ-009 SHALL have port data, input, 32, CPU store data.
REQ-010 SHALL have port q_mmio, output, 32, read data for addresses 0-15.
REQ-011 SHALL have port is_mmio_rd, output, 1, high when address_dmem < 16.
REQ-012 SHALL have port in_raw, input, NUM_IN, asynchronous sensor levels.
REQ-013 SHALL have port out_regs, output, NUM_OUT*32, register j at bits [32j+31:32j].
REQ-014 SHALL have port event_pending, output, 1, high when any channel counter is nonzero.

Function
REQ-015 SHALL pass each in_raw bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL rising-edge detect each filtered level; one edge yields exactly one increment pulse.
REQ-017 SHALL keep a per-channel CNT_W counter that increments on an edge and saturates at all-ones.
REQ-018 SHALL return q_mmio combinationally for address i < NUM_IN as {zeros, count_i, level_i}, with count in bits [CNT_W:1] and level in bit 0.
REQ-019 SHALL return at address 15 a status word whose bit i is 1 when count_i != 0; other read addresses < 16 SHALL return 0.
REQ-020 SHALL clear counter i at the clock edge where wren=1 and address_dmem=i, for i < NUM_IN.
REQ-021 SHALL set counter i to 1, not 0, when a clear and an edge coincide in the same cycle.
REQ-022 SHALL load out_regs[j] with data when wren=1 and address_dmem=16+j, for j < NUM_OUT.
REQ-023 SHALL ignore stores to addresses 16+NUM_OUT..31 and to unused 0..15 addresses, with no state change.
REQ-024 SHALL leave all hub state unchanged for any address >= 32.
REQ-025 SHALL give the write path one cycle of latency: a store at edge N is visible on out_regs after edge N.
REQ-026 SHALL register event_pending, so it reflects counter state one cycle later.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, zero all counters, out_regs, synchronizers, filter state and event_pending.
REQ-028 SHALL discard an edge that is in flight when reset is asserted, and SHALL NOT count it after reset releases.
REQ-029 SHALL NOT count a level that is already high at reset release until it falls and rises again.

Configuration
REQ-030 SHALL, with MMIO_HUB_DEBOUNCE_EN defined, pass a new synchronized level to the edge detector only after DEB_CYCLES consecutive equal samples; a shorter pulse is dropped.
REQ-031 SHALL, without MMIO_HUB_DEBOUNCE_EN defined, feed the synchronized level straight to the edge detector and omit the filter logic entirely.

Structure
REQ-032 SHALL put the address constants (READ_STATUS_ADDR=15, WRITE_BASE=16, MMIO_LIMIT=32) and the read-word field layout in shared package mmio_pkg.
REQ-033 SHALL implement each input channel (synchronizer, optional filter, edge detector, counter) in one sub-module, mmio_in_chan, instantiated NUM_IN times.

Verification
REQ-034 SHALL test this: three clean 10-cycle pulses on in_raw[1] (debounce off) -> read of address 1 returns 0x6 while high-level is 0.
REQ-035 SHALL test this: 300 edges on ch0 with CNT_W=8 -> count holds 255; status bit0=1; event_pending=1.
REQ-036 SHALL test this: store to address 2 in the same cycle as an edge on ch2 -> count_2=1 next cycle.
REQ-037 SHALL test this: store 0x5A to address 23 -> out_regs[7]=0x5A next cycle; store to address 30 (NUM_OUT=9) -> no out_regs change.
REQ-038 SHALL test this: with MMIO_HUB_DEBOUNCE_EN and DEB_CYCLES=1000, a 500-cycle pulse -> count 0; a 1500-cycle pulse -> count 1.
REQ-039 SHALL test this: reset=0 mid-pulse with count_3=4 -> all outputs 0; in_raw[3] held high after release -> count stays 0.
